// File: rtl/risc_v_mike_pkg.sv
// Shared core types: register addressing, write-back request bundle and source IDs.
package risc_v_mike_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_32_W  = 32;

  typedef logic [REG_ADDR_W-1:0] t_register_addr;

  typedef struct packed {
    logic                 valid;
    t_register_addr       addr;
    logic [DATA_32_W-1:0] data;
  } t_wb_req;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } t_wb_src;

endpackage

// File: rtl/risc_v_mike_rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the ALU, bit 1 the LSU.
// On a tie the requester not granted last wins; the pointer only moves when a
// grant is issued, and since ready equals grant every grant is a transfer.
module risc_v_mike_rr_arb2
  import risc_v_mike_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output t_wb_src    winner_o
);

  t_wb_src last_q, last_d;

  // Pick a winner from the requests and the last-granted pointer.
  always_comb begin
    gnt_o    = '0;
    winner_o = WB_SRC_ALU;
    last_d   = last_q;
    if (req_i[0] && req_i[1]) begin
      winner_o = (last_q == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    end else if (req_i[1]) begin
      winner_o = WB_SRC_LSU;
    end else begin
      winner_o = WB_SRC_ALU;
    end
    if (|req_i) begin
      gnt_o[winner_o] = 1'b1;
      last_d          = winner_o;
    end
  end

  // Last-granted pointer; starts at ALU so the LSU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= WB_SRC_ALU;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/risc_v_mike_wb_sched.sv
// Write-back scheduler and register scoreboard: arbitrates ALU/LSU results onto
// the single register-file write port and stalls issue on RAW/WAW hazards.
module risc_v_mike_wb_sched
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned REG_FILE_DEPTH = 16,
  parameter int unsigned DATA_W         = DATA_32_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_valid,
  input  logic                      iss_rd_en,
  input  t_register_addr            iss_rd,
  input  t_register_addr            iss_rs1,
  input  t_register_addr            iss_rs2,
  output logic                      iss_stall,
  input  logic                      alu_wb_valid,
  input  t_register_addr            alu_wb_addr,
  input  logic [DATA_W-1:0]         alu_wb_data,
  output logic                      alu_wb_ready,
  input  logic                      lsu_wb_valid,
  input  t_register_addr            lsu_wb_addr,
  input  logic [DATA_W-1:0]         lsu_wb_data,
  output logic                      lsu_wb_ready,
  output logic                      reg_file_write,
  output t_register_addr            reg_file_wr_addr,
  output logic [DATA_W-1:0]         reg_file_wr_data,
  output logic [REG_FILE_DEPTH-1:0] busy_vec,
  output logic                      wb_err
);

  logic [1:0]          req, gnt;
  t_wb_src             winner;
  logic                xfer;
  t_register_addr      sel_addr;
  logic [DATA_W-1:0]   sel_data;

  logic                wr_q;
  t_register_addr      addr_q;
  logic [DATA_W-1:0]   data_q;

  logic [REG_FILE_DEPTH-1:0] busy_q, busy_d, set_vec, clr_vec;
  logic                      err_q, err_d;

  assign req = {lsu_wb_valid, alu_wb_valid};

  risc_v_mike_rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign alu_wb_ready = gnt[0];
  assign lsu_wb_ready = gnt[1];
  assign xfer         = |(req & gnt);

  // Route the winning requester's address and data to the write stage.
  always_comb begin
    sel_addr = alu_wb_addr;
    sel_data = alu_wb_data;
    if (winner == WB_SRC_LSU) begin
      sel_addr = lsu_wb_addr;
      sel_data = lsu_wb_data;
    end
  end

  // Registered write port; x0 transfers are accepted but never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q <= xfer && (sel_addr != '0);
      if (xfer && (sel_addr != '0)) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
    end
  end

  assign iss_stall = iss_valid &
                     (busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_rd_en & busy_q[iss_rd]));

  // Scoreboard update: clear on the write edge, set on issue; set wins on overlap.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_q) clr_vec[addr_q] = 1'b1;
    if (iss_valid && iss_rd_en && !iss_stall && (iss_rd != '0)) set_vec[iss_rd] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    err_d     = err_q | (wr_q && !busy_q[addr_q] && (addr_q != '0));
  end

  // Scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign reg_file_write   = wr_q;
  assign reg_file_wr_addr = addr_q;
  assign reg_file_wr_data = data_q;
  assign busy_vec         = busy_q;
  assign wb_err           = err_q;

endmodule
